// File: rtl/fm_tx_mod.sv
`default_nettype none
// ============================================================================
// fm_tx_mod : DDS FM modulator, FIFO-fed or sweep-driven frequency deviation
// Revision  : 1.0
// ============================================================================
module fm_tx_mod #(
   parameter int P_ACC_W  = 32,
   parameter int P_SMP_W  = 16,
   parameter int P_DEPTH  = 4,
   parameter int P_RATE_W = 16
) (
   input  logic                i_clk,
   input  logic                i_nrst,
   input  logic [1:0]          i_mode,
   input  logic [P_ACC_W-1:0]  i_base_inc,
   input  logic [4:0]          i_dev_shift,
   input  logic [P_RATE_W-1:0] i_rate,
   input  logic [P_SMP_W-1:0]  i_smp_data,
   input  logic                i_smp_valid,
   output logic                o_smp_ready,
   output logic                o_fm,
   output logic                o_underrun
);

   localparam int C_PTR_W = $clog2(P_DEPTH);
   localparam logic [C_PTR_W:0] C_DEPTH = (C_PTR_W+1)'(P_DEPTH);

   localparam logic [1:0] C_MODE_OFF   = 2'd0;
   localparam logic [1:0] C_MODE_CAR   = 2'd1;
   localparam logic [1:0] C_MODE_SWEEP = 2'd2;
   localparam logic [1:0] C_MODE_SMP   = 2'd3;

   logic [1:0]          mode_q;
   logic [P_RATE_W-1:0] rate_cnt_q, rate_cnt_d;
   logic [P_SMP_W-1:0]  hold_q, hold_d;
   logic [P_ACC_W-1:0]  inc_q, inc_d;
   logic [P_ACC_W-1:0]  acc_q, acc_d;
   logic                fm_d, underrun_d, ready_d;

   logic [P_SMP_W-1:0]  mem_q [P_DEPTH];
   logic [C_PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
   logic [C_PTR_W:0]    count_q, count_d;

   logic                w_mode_chg, w_tick, w_empty, w_flush, w_push, w_pop;
   logic [P_ACC_W-1:0]  w_hold_ext, w_dev;

   assign w_mode_chg = (i_mode != mode_q);
   assign w_tick     = (rate_cnt_q == i_rate);
   assign w_empty    = (count_q == '0);
   assign w_flush    = w_mode_chg && (i_mode != C_MODE_SMP);
   assign w_push     = i_smp_valid && o_smp_ready && !w_flush;
   assign w_pop      = !w_mode_chg && w_tick && (mode_q == C_MODE_SMP) && !w_empty;

   assign w_hold_ext = {{(P_ACC_W-P_SMP_W){hold_q[P_SMP_W-1]}}, hold_q};
   assign w_dev      = w_hold_ext << i_dev_shift;

   always_comb begin
      rate_cnt_d = (w_mode_chg || w_tick) ? '0 : rate_cnt_q + 1'b1;

      hold_d     = hold_q;
      underrun_d = o_underrun;
      if (w_mode_chg) begin
         hold_d     = '0;
         underrun_d = 1'b0;
      end else if (w_tick) begin
         case (mode_q)
            C_MODE_SWEEP: hold_d = hold_q + 1'b1;
            C_MODE_SMP: begin
               if (w_empty) begin
                  hold_d     = '0;
                  underrun_d = 1'b1;
               end else begin
                  hold_d = mem_q[rd_ptr_q];
               end
            end
            default: hold_d = '0;
         endcase
      end

      // Carrier mode transmits the bare tuning word regardless of hold
      inc_d = i_base_inc + ((mode_q == C_MODE_CAR) ? '0 : w_dev);
      acc_d = (mode_q == C_MODE_OFF) ? '0 : acc_q + inc_q;
      fm_d  = (mode_q == C_MODE_OFF) ? 1'b0 : acc_q[P_ACC_W-1];

      if (w_flush) begin
         count_d = '0;
      end else begin
         count_d = count_q + {{C_PTR_W{1'b0}}, w_push} - {{C_PTR_W{1'b0}}, w_pop};
      end
      ready_d = (i_mode == C_MODE_SMP) && (count_d < C_DEPTH);
   end

   always_ff @(posedge i_clk) begin
      if (!i_nrst) begin
         mode_q      <= C_MODE_OFF;
         rate_cnt_q  <= '0;
         hold_q      <= '0;
         inc_q       <= '0;
         acc_q       <= '0;
         o_fm        <= 1'b0;
         o_underrun  <= 1'b0;
         o_smp_ready <= 1'b0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
      end else begin
         mode_q      <= i_mode;
         rate_cnt_q  <= rate_cnt_d;
         hold_q      <= hold_d;
         inc_q       <= inc_d;
         acc_q       <= acc_d;
         o_fm        <= fm_d;
         o_underrun  <= underrun_d;
         o_smp_ready <= ready_d;
         count_q     <= count_d;
         if (w_flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
         end else begin
            if (w_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (w_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         end
      end
   end

   // Storage needs no reset: pointers and count define what is valid
   always_ff @(posedge i_clk) begin
      if (i_nrst && w_push) begin
         mem_q[wr_ptr_q] <= i_smp_data;
      end
   end

endmodule
`default_nettype wire
